// File: rtl/miss_pkg.sv
// Shared types and sizing helpers for the miss refill controller.
package miss_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  // A single-beat line still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/miss_fifo.sv
// Miss address FIFO with extra-bit pointers for full/empty.
// With MISS_DEDUP_EN defined it also reports whether match_addr is held in any valid entry.
module miss_fifo
  import miss_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic              full,
  output logic              empty
`ifdef MISS_DEDUP_EN
  ,
  input  logic [ADDR_W-1:0] match_addr,
  output logic              match
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_addr = mem[rd_ptr[PTR_W-1:0]];

  // Pointer and storage update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr[PTR_W-1:0]] <= push_addr;
        wr_ptr                 <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

`ifdef MISS_DEDUP_EN
  logic [PTR_W:0]   used;
  logic [PTR_W-1:0] off;

  assign used = wr_ptr - rd_ptr;

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    match = 1'b0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off   = PTR_W'(i) - rd_ptr[PTR_W-1:0];
      match = match | (({1'b0, off} < used) && (mem[i] == match_addr));
    end
  end
`endif

endmodule

// File: rtl/miss_refill_ctrl.sv
// Queues cache-miss line addresses and refills each line from memory, beat by beat.
// Optional MISS_DEDUP_EN drops misses already queued or in flight.
module miss_refill_ctrl
  import miss_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH      = 8,
  parameter int LINE_BEATS = 4,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_last,
  output logic              busy,
  output logic [15:0]       miss_count
);

  localparam int                BEAT_W    = cnt_width(LINE_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  state_t            state;
  state_t            next_state;
  logic [BEAT_W-1:0] beat_cnt;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] head_addr;
  logic              accept;
  logic              dup;
  logic              push;
  logic              beat_fire;
  logic              last_fire;

  assign miss_ready = !full;
  assign busy       = (state != IDLE) || !empty;
  assign accept     = miss_valid && !full;
  assign push       = accept && !dup;
  assign beat_fire  = (state == DATA) && mem_rvalid;
  assign last_fire  = beat_fire && (beat_cnt == LAST_BEAT);

`ifdef MISS_DEDUP_EN
  logic fifo_match;

  assign dup = fifo_match || ((state != IDLE) && (mem_addr == miss_addr));

  miss_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_addr  (miss_addr),
    .pop        (last_fire),
    .head_addr  (head_addr),
    .full       (full),
    .empty      (empty),
    .match_addr (miss_addr),
    .match      (fifo_match)
  );
`else
  assign dup = 1'b0;

  miss_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (miss_addr),
    .pop       (last_fire),
    .head_addr (head_addr),
    .full      (full),
    .empty     (empty)
  );
`endif

  // Next-state selection
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!empty) begin
          next_state = REQ;
        end else begin
          next_state = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) begin
          next_state = DATA;
        end else begin
          next_state = REQ;
        end
      end
      DATA: begin
        if (last_fire) begin
          next_state = IDLE;
        end else begin
          next_state = DATA;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Memory request side; the address is captured only when leaving IDLE so it stays stable in REQ/DATA
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      beat_cnt <= '0;
    end else begin
      mem_req <= (next_state == REQ);
      if ((state == IDLE) && !empty) begin
        mem_addr <= head_addr;
      end
      if (state == REQ) begin
        beat_cnt <= '0;
      end else if (beat_fire) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end

  // Registered fill port, one cycle behind each accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_data  <= '0;
      fill_last  <= 1'b0;
    end else begin
      fill_valid <= beat_fire;
      fill_last  <= last_fire;
      if (beat_fire) begin
        fill_addr <= mem_addr;
        fill_data <= mem_rdata;
      end
    end
  end

  // Saturating count of enqueued misses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_count <= 16'h0000;
    end else if (push && (miss_count != 16'hFFFF)) begin
      miss_count <= miss_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_miss_refill_ctrl.sv
// Self-checking bench for miss_refill_ctrl: directed scenarios plus a randomized run
// against a queue-based reference model. Honours MISS_DEDUP_EN when defined.
module tb_miss_refill_ctrl;

  localparam int DEPTH = 8;
  localparam int LB    = 4;

  logic        clk;
  logic        rst;
  logic        miss_valid;
  logic [9:0]  miss_addr;
  logic        miss_ready;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        fill_valid;
  logic [9:0]  fill_addr;
  logic [31:0] fill_data;
  logic        fill_last;
  logic        busy;
  logic [15:0] miss_count;

  int tests = 0;
  int fails = 0;

  miss_refill_ctrl #(.ADDR_W(10), .DEPTH(DEPTH), .LINE_BEATS(LB), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .miss_valid (miss_valid),
    .miss_addr  (miss_addr),
    .miss_ready (miss_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data),
    .fill_last  (fill_last),
    .busy       (busy),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst        = 1'b1;
    miss_valid = 1'b0;
    miss_addr  = 10'h000;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int w;
    w = 0;
    while (mem_req !== 1'b1 && w < 30) begin
      @(negedge clk);
      w++;
    end
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL %s_req_timeout: mem_req=%b after %0d cycles, want 1", name, mem_req, w);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({miss_ready, mem_req, fill_valid, fill_last, busy} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 10000", {miss_ready, mem_req, fill_valid, fill_last, busy});
    end
    tests++;
    if ({mem_addr, fill_addr, fill_data, miss_count} !== 68'h0) begin
      fails++;
      $display("FAIL reset_data: mem_addr=%h fill_addr=%h fill_data=%h miss_count=%h want 0",
               mem_addr, fill_addr, fill_data, miss_count);
    end
  endtask

  task automatic test_single();
    int fills;
    do_reset();
    miss_valid = 1'b1;
    miss_addr  = 10'h1ED;
    @(negedge clk);
    miss_valid = 1'b0;
    tests++;
    if (mem_req !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_latency: mem_req=%b busy=%b want 0/1", mem_req, busy);
    end
    @(negedge clk);
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 10'h1ED) begin
      fails++;
      $display("FAIL single_req: mem_req=%b mem_addr=%h want 1/1ed", mem_req, mem_addr);
    end
    @(negedge clk);
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL single_req_hold: mem_req=%b want 1", mem_req);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("FAIL single_req_drop: mem_req=%b want 0", mem_req);
    end
    fills = 0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hA0 + i;
      @(negedge clk);
      if (fill_valid === 1'b1) fills++;
      tests++;
      if (fill_data !== 32'hA0 + i || fill_last !== (i == 3) || fill_addr !== 10'h1ED) begin
        fails++;
        $display("FAIL single_beat%0d: data=%h last=%b addr=%h want %h/%b/1ed",
                 i, fill_data, fill_last, fill_addr, 32'hA0 + i, (i == 3));
      end
    end
    mem_rvalid = 1'b0;
    @(negedge clk);
    tests++;
    if (fills != 4 || fill_valid !== 1'b0 || busy !== 1'b0 || miss_count !== 16'd1) begin
      fails++;
      $display("FAIL single_done: fills=%0d fill_valid=%b busy=%b count=%0d want 4/0/0/1",
               fills, fill_valid, busy, miss_count);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (miss_ready !== (i < 8)) begin
        fails++;
        $display("FAIL full_ready%0d: miss_ready=%b want %b", i, miss_ready, (i < 8));
      end
      miss_valid = 1'b1;
      miss_addr  = 10'h040 + 10'(i);
      @(negedge clk);
    end
    repeat (3) begin
      tests++;
      if (miss_ready !== 1'b0 || miss_count !== 16'd8) begin
        fails++;
        $display("FAIL full_hold: miss_ready=%b count=%0d want 0/8", miss_ready, miss_count);
      end
      @(negedge clk);
    end
    wait_req("full");
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int b = 0; b < LB; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0;
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    tests++;
    if (miss_ready !== 1'b1 || miss_count !== 16'd8) begin
      fails++;
      $display("FAIL full_no_bypass: miss_ready=%b count=%0d want 1/8", miss_ready, miss_count);
    end
    @(negedge clk);
    miss_valid = 1'b0;
    tests++;
    if (miss_ready !== 1'b0 || miss_count !== 16'd9) begin
      fails++;
      $display("FAIL full_ninth: miss_ready=%b count=%0d want 0/9", miss_ready, miss_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    miss_valid = 1'b1;
    miss_addr  = 10'h2AA;
    @(negedge clk);
    miss_valid = 1'b0;
    wait_req("rstmid");
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hC0 + b;
      @(negedge clk);
    end
    mem_rdata = 32'hC2;
    rst = 1'b1;
    #1;
    tests++;
    if ({mem_req, fill_valid, busy, miss_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL rstmid_async: req/fill/busy/ready=%b want 0001", {mem_req, fill_valid, busy, miss_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      tests++;
      if (fill_valid !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_after%0d: fill_valid=%b mem_req=%b busy=%b want 0", b, fill_valid, mem_req, busy);
      end
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_stray_rvalid();
    do_reset();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD;
    repeat (2) begin
      @(negedge clk);
      tests++;
      if (fill_valid !== 1'b0) begin
        fails++;
        $display("FAIL stray_idle: fill_valid=%b want 0", fill_valid);
      end
    end
    miss_valid = 1'b1;
    miss_addr  = 10'h155;
    @(negedge clk);
    miss_valid = 1'b0;
    wait_req("stray");
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if (fill_valid !== 1'b0) begin
      fails++;
      $display("FAIL stray_req: fill_valid=%b want 0", fill_valid);
    end
    for (int i = 0; i < LB; i++) begin
      mem_rdata = 32'hB0 + i;
      @(negedge clk);
      tests++;
      if (fill_valid !== 1'b1 || fill_last !== (i == LB - 1) || fill_data !== 32'hB0 + i) begin
        fails++;
        $display("FAIL stray_beat%0d: valid=%b last=%b data=%h want 1/%b/%h",
                 i, fill_valid, fill_last, fill_data, (i == LB - 1), 32'hB0 + i);
      end
    end
    mem_rvalid = 1'b0;
    @(negedge clk);
    tests++;
    if (fill_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL stray_done: fill_valid=%b busy=%b want 0/0", fill_valid, busy);
    end
  endtask

  task automatic test_dedup();
    logic [9:0] exp_addr [3];
    int         exp_n;
`ifdef MISS_DEDUP_EN
    exp_n = 2;
    exp_addr[0] = 10'h1F4; exp_addr[1] = 10'h1C0; exp_addr[2] = 10'h000;
`else
    exp_n = 3;
    exp_addr[0] = 10'h1F4; exp_addr[1] = 10'h1F4; exp_addr[2] = 10'h1C0;
`endif
    do_reset();
    miss_valid = 1'b1;
    miss_addr  = 10'h1F4;
    @(negedge clk);
    @(negedge clk);
    miss_addr = 10'h1C0;
    @(negedge clk);
    miss_valid = 1'b0;
    for (int r = 0; r < exp_n; r++) begin
      wait_req("dedup");
      tests++;
      if (mem_addr !== exp_addr[r]) begin
        fails++;
        $display("FAIL dedup_addr%0d: mem_addr=%h want %h", r, mem_addr, exp_addr[r]);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rvalid = 1'b1;
      repeat (LB) @(negedge clk);
      mem_rvalid = 1'b0;
    end
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || miss_count !== 16'(exp_n)) begin
      fails++;
      $display("FAIL dedup_end: busy=%b mem_req=%b count=%0d want 0/0/%0d", busy, mem_req, miss_count, exp_n);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_c [3];
    exp_c[0] = 16'hFFFE; exp_c[1] = 16'hFFFF; exp_c[2] = 16'hFFFF;
    do_reset();
    force dut.miss_count = 16'hFFFD;
    #1;
    release dut.miss_count;
    for (int i = 0; i < 3; i++) begin
      miss_valid = 1'b1;
      miss_addr  = 10'h300 + 10'(i);
      @(negedge clk);
      tests++;
      if (miss_count !== exp_c[i]) begin
        fails++;
        $display("FAIL sat%0d: miss_count=%h want %h", i, miss_count, exp_c[i]);
      end
    end
    miss_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [9:0]  q [$];
    int          phase;
    int          beats;
    int          cnt;
    logic [9:0]  req_addr;
    logic        exp_fill;
    logic [31:0] exp_data;
    logic [9:0]  exp_faddr;
    logic        exp_last;
    logic        dup;
    logic        last_beat;
    int          old_size;
    do_reset();
    phase = 0; beats = 0; cnt = 0; req_addr = '0;
    exp_fill = 1'b0; exp_data = '0; exp_faddr = '0; exp_last = 1'b0;
    for (int cyc = 0; cyc < 2400; cyc++) begin
      tests++;
      if (miss_ready !== (q.size() < DEPTH) || busy !== (phase != 0 || q.size() > 0) ||
          miss_count !== 16'(cnt)) begin
        fails++;
        $display("FAIL rand_status c%0d: ready=%b busy=%b count=%0d want %b/%b/%0d", cyc, miss_ready, busy,
                 miss_count, (q.size() < DEPTH), (phase != 0 || q.size() > 0), cnt);
      end
      tests++;
      if (mem_req !== (phase == 1) || (phase == 1 && mem_addr !== req_addr)) begin
        fails++;
        $display("FAIL rand_req c%0d: mem_req=%b mem_addr=%h want %b/%h", cyc, mem_req, mem_addr, (phase == 1), req_addr);
      end
      tests++;
      if (fill_valid !== exp_fill ||
          (exp_fill && (fill_data !== exp_data || fill_addr !== exp_faddr || fill_last !== exp_last))) begin
        fails++;
        $display("FAIL rand_fill c%0d: v=%b d=%h a=%h l=%b want %b/%h/%h/%b", cyc, fill_valid, fill_data,
                 fill_addr, fill_last, exp_fill, exp_data, exp_faddr, exp_last);
      end
      miss_valid = (cyc < 2000) && ($urandom_range(0, 2) == 0);
      miss_addr  = 10'h100 + 10'($urandom_range(0, 15));
      mem_ack    = (phase == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      old_size   = q.size();
      exp_fill   = 1'b0;
      last_beat  = 1'b0;
      if (phase == 0) begin
        if (old_size > 0) begin
          phase    = 1;
          req_addr = q[0];
        end
      end else if (phase == 1) begin
        if (mem_ack) begin
          phase = 2;
          beats = 0;
        end
      end else if (mem_rvalid) begin
        exp_fill  = 1'b1;
        exp_data  = mem_rdata;
        exp_faddr = req_addr;
        exp_last  = (beats == LB - 1);
        last_beat = exp_last;
        beats++;
      end
      dup = 1'b0;
`ifdef MISS_DEDUP_EN
      foreach (q[k]) if (q[k] == miss_addr) dup = 1'b1;
`endif
      if (miss_valid && old_size < DEPTH && !dup) begin
        q.push_back(miss_addr);
        if (cnt < 65535) cnt++;
      end
      if (last_beat) begin
        void'(q.pop_front());
        phase = 0;
      end
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    mem_ack    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_reset_mid();
    test_stray_rvalid();
    test_dedup();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
